// File: rtl/bus_slave_ram.sv
// bus_slave_ram: single-window bus responder backed by a DEPTH x DATA_W
// register array. A selected request is captured, held for WAIT wait-state
// cycles, then completed with a one-cycle s_ack. Read data is presented in
// the ack cycle and held until the next read completes.
module bus_slave_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 32,
  parameter int WAIT   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_sel,
  input  logic              s_req,
  input  logic              s_wr,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_wdata,
  output logic [DATA_W-1:0] s_rdata,
  output logic              s_ack
);

  localparam int OFF_W = $clog2(DEPTH);
  // Counter preload: the WAIT state lasts until the counter has reached 0,
  // so loading WAIT-1 yields exactly WAIT wait-state cycles.
  localparam logic [3:0] WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [3:0]         cnt_reg;
  logic [OFF_W-1:0]   off_reg;
  logic               wr_reg;
  logic [DATA_W-1:0]  wdata_reg;
  logic [DATA_W-1:0]  rdata_reg;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic               start;
  logic [OFF_W-1:0]   rd_off;
  logic               rd_is_write;

  // Upper address bits alias onto the same window and are deliberately unused.
  logic               addr_hi_unused;
  assign addr_hi_unused = ^s_addr[ADDR_W-1:OFF_W];

  assign start   = s_sel & s_req;
  assign s_rdata = rdata_reg;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: IDLE waits for a selected request, WAIT runs the
  // counter down, ACK always returns to IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = (WAIT > 0) ? ST_WAIT : ST_ACK;
        end
      end
      ST_WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = ST_ACK;
        end
      end
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode: acknowledge is high for the single ACK cycle.
  always_comb begin
    s_ack = 1'b0;
    if (state_reg == ST_ACK) begin
      s_ack = 1'b1;
    end
  end

  // Request capture and wait-state counter; inputs outside IDLE are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg   <= 4'd0;
      off_reg   <= '0;
      wr_reg    <= 1'b0;
      wdata_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            off_reg   <= s_addr[OFF_W-1:0];
            wr_reg    <= s_wr;
            wdata_reg <= s_wdata;
            cnt_reg   <= WAIT_LOAD;
          end
        end
        ST_WAIT: begin
          if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // With no wait states ACK is entered on the capture edge itself, so the
  // read offset must come straight from the bus in that case.
  always_comb begin
    rd_off      = off_reg;
    rd_is_write = wr_reg;
    if (state_reg == ST_IDLE) begin
      rd_off      = s_addr[OFF_W-1:0];
      rd_is_write = s_wr;
    end
  end

  // Read data register: loaded on entry to ACK for reads only, so it holds
  // its value through writes and idle cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_reg <= '0;
    end else if ((state_next == ST_ACK) && (state_reg != ST_ACK) && !rd_is_write) begin
      rdata_reg <= mem[rd_off];
    end
  end

  // Backing store: cleared on reset, write commits at the edge ending ACK.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if ((state_reg == ST_ACK) && wr_reg) begin
      mem[off_reg] <= wdata_reg;
    end
  end

endmodule

// File: tb/tb_bus_slave_ram.sv
// tb_bus_slave_ram: directed tests for bus_slave_ram. Four instances share
// the bus: WAIT=1, WAIT=0, WAIT=3, and a WAIT=1 instance used for the s1
// window aliasing test. Each instance has its own select.
module tb_bus_slave_ram;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  sel;
  logic        s_req;
  logic        s_wr;
  logic [7:0]  s_addr;
  logic [31:0] s_wdata;

  logic        ack_w1, ack_w0, ack_w3, ack_s1;
  logic [31:0] rd_w1, rd_w0, rd_w3, rd_s1;
  logic [3:0]  ack_v;
  logic [31:0] rdata_v [4];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign ack_v      = {ack_s1, ack_w3, ack_w0, ack_w1};
  assign rdata_v[0] = rd_w1;
  assign rdata_v[1] = rd_w0;
  assign rdata_v[2] = rd_w3;
  assign rdata_v[3] = rd_s1;

  bus_slave_ram #(.DATA_W(32), .ADDR_W(8), .DEPTH(32), .WAIT(1)) u_w1 (
    .clk(clk), .reset_n(reset_n), .s_sel(sel[0]), .s_req(s_req), .s_wr(s_wr),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(rd_w1), .s_ack(ack_w1));

  bus_slave_ram #(.DATA_W(32), .ADDR_W(8), .DEPTH(32), .WAIT(0)) u_w0 (
    .clk(clk), .reset_n(reset_n), .s_sel(sel[1]), .s_req(s_req), .s_wr(s_wr),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(rd_w0), .s_ack(ack_w0));

  bus_slave_ram #(.DATA_W(32), .ADDR_W(8), .DEPTH(32), .WAIT(3)) u_w3 (
    .clk(clk), .reset_n(reset_n), .s_sel(sel[2]), .s_req(s_req), .s_wr(s_wr),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(rd_w3), .s_ack(ack_w3));

  bus_slave_ram #(.DATA_W(32), .ADDR_W(8), .DEPTH(32), .WAIT(1)) u_s1 (
    .clk(clk), .reset_n(reset_n), .s_sel(sel[3]), .s_req(s_req), .s_wr(s_wr),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(rd_s1), .s_ack(ack_s1));

  // One transaction on instance inst. Latency is the number of falling edges
  // after the sampling edge until ack is seen (-1 on timeout). With drop set,
  // the master releases s_req/s_sel right after the request has been sampled.
  task automatic do_txn(input int inst, input logic wr, input logic [7:0] addr,
                        input logic [31:0] wdata, input logic drop,
                        output int lat, output logic [31:0] rd, output logic ack_after);
    logic got;
    @(negedge clk);
    sel     = 4'(1 << inst);
    s_req   = 1'b1;
    s_wr    = wr;
    s_addr  = addr;
    s_wdata = wdata;
    lat = -1;
    rd  = 32'h0;
    got = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (drop && k == 1) begin
        sel   = 4'b0;
        s_req = 1'b0;
      end
      if (ack_v[inst]) begin
        got = 1'b1;
        lat = k;
        rd  = rdata_v[inst];
      end
    end
    sel   = 4'b0;
    s_req = 1'b0;
    @(negedge clk);
    ack_after = ack_v[inst];
    $display("[TB] txn inst=%0d %s addr=0x%02h wdata=0x%08h lat=%0d rdata=0x%08h",
             inst, wr ? "WR" : "RD", addr, wdata, lat, rd);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    sel = 4'b0; s_req = 1'b0; s_wr = 1'b0; s_addr = 8'h0; s_wdata = 32'h0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (ack_v !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ack: got %b expected 0000", ack_v);
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (rdata_v[i] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_rdata[%0d]: got 0x%08h expected 0x00000000", i, rdata_v[i]);
      end
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    int lat; logic [31:0] rd; logic aa; int pulses;
    do_txn(2, 1'b1, 8'h04, 32'h11111111, 1'b0, lat, rd, aa);
    do_txn(2, 1'b0, 8'h04, 32'h0, 1'b0, lat, rd, aa);
    n_tests++;
    if (rd !== 32'h11111111) begin
      n_fail++;
      $display("FAIL pre_reset_read: got 0x%08h expected 0x11111111", rd);
    end
    // Write 0xDEADBEEF@0x03 and reset while it sits in WAIT.
    @(negedge clk);
    sel = 4'b0100; s_req = 1'b1; s_wr = 1'b1; s_addr = 8'h03; s_wdata = 32'hDEADBEEF;
    @(negedge clk);
    reset_n = 1'b0;
    sel = 4'b0; s_req = 1'b0;
    pulses = 0;
    @(negedge clk);
    if (ack_w3) pulses++;
    n_tests++;
    if (rd_w3 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rdata_clear: got 0x%08h expected 0x00000000", rd_w3);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ack_w3) pulses++;
    end
    n_tests++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL reset_no_ack: got %0d ack pulses expected 0", pulses);
    end
    do_txn(2, 1'b0, 8'h03, 32'h0, 1'b0, lat, rd, aa);
    n_tests++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_dropped_write: got 0x%08h expected 0x00000000", rd);
    end
    do_txn(2, 1'b0, 8'h04, 32'h0, 1'b0, lat, rd, aa);
    n_tests++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mem_clear: got 0x%08h expected 0x00000000", rd);
    end
  endtask

  task automatic test_wait1();
    int lat; logic [31:0] rd; logic aa;
    do_txn(0, 1'b1, 8'h05, 32'h12345678, 1'b0, lat, rd, aa);
    n_tests++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL w1_write_latency: got %0d expected 2", lat);
    end
    n_tests++;
    if (aa !== 1'b0) begin
      n_fail++;
      $display("FAIL w1_write_ack_width: ack after got %b expected 0", aa);
    end
    do_txn(0, 1'b0, 8'h05, 32'h0, 1'b0, lat, rd, aa);
    n_tests++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL w1_read_latency: got %0d expected 2", lat);
    end
    n_tests++;
    if (rd !== 32'h12345678) begin
      n_fail++;
      $display("FAIL w1_read_data: got 0x%08h expected 0x12345678", rd);
    end
    n_tests++;
    if (aa !== 1'b0) begin
      n_fail++;
      $display("FAIL w1_read_ack_width: ack after got %b expected 0", aa);
    end
    // A write must not disturb the held read data.
    do_txn(0, 1'b1, 8'h06, 32'h00000055, 1'b0, lat, rd, aa);
    n_tests++;
    if (rd_w1 !== 32'h12345678) begin
      n_fail++;
      $display("FAIL w1_rdata_hold: got 0x%08h expected 0x12345678", rd_w1);
    end
  endtask

  task automatic test_back_to_back();
    int cnt; int exp_cnt; logic got; int lat; logic [31:0] rd; logic aa;
    @(negedge clk);
    sel = 4'b0010; s_req = 1'b1; s_wr = 1'b1; s_addr = 8'h00; s_wdata = 32'h0;
    for (int a = 0; a < 32; a++) begin
      cnt = -1;
      got = 1'b0;
      for (int k = 1; k <= 10 && !got; k++) begin
        @(negedge clk);
        if (ack_w0) begin
          got = 1'b1;
          cnt = k;
        end
      end
      exp_cnt = (a == 0) ? 1 : 2;
      $display("[TB] txn inst=1 WR addr=0x%02h wdata=0x%08h gap=%0d", s_addr, s_wdata, cnt);
      n_tests++;
      if (cnt !== exp_cnt) begin
        n_fail++;
        $display("FAIL b2b_ack_spacing[%0d]: got %0d expected %0d", a, cnt, exp_cnt);
      end
      if (a < 31) begin
        s_addr  = 8'(a + 1);
        s_wdata = 32'((a + 1) * 3);
      end else begin
        s_req = 1'b0;
        sel   = 4'b0;
      end
    end
    do_txn(1, 1'b0, 8'h1F, 32'h0, 1'b0, lat, rd, aa);
    n_tests++;
    if (rd !== 32'h0000005D) begin
      n_fail++;
      $display("FAIL b2b_read_1f: got 0x%08h expected 0x0000005d", rd);
    end
    n_tests++;
    if (lat !== 1) begin
      n_fail++;
      $display("FAIL w0_read_latency: got %0d expected 1", lat);
    end
    do_txn(1, 1'b0, 8'h10, 32'h0, 1'b0, lat, rd, aa);
    n_tests++;
    if (rd !== 32'h00000030) begin
      n_fail++;
      $display("FAIL b2b_read_10: got 0x%08h expected 0x00000030", rd);
    end
  endtask

  task automatic test_no_sel();
    int acks; int bad_rd; int lat; logic [31:0] rd; logic aa;
    acks = 0;
    bad_rd = 0;
    @(negedge clk);
    sel = 4'b0; s_req = 1'b1; s_wr = 1'b1; s_addr = 8'h07; s_wdata = 32'hFFFFFFFF;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ack_v != 4'b0) acks++;
      if (rd_w1 !== 32'h12345678) bad_rd++;
    end
    s_req = 1'b0;
    $display("[TB] txn unselected WR addr=0x07 wdata=0xffffffff acks=%0d", acks);
    n_tests++;
    if (acks !== 0) begin
      n_fail++;
      $display("FAIL nosel_ack: got %0d ack cycles expected 0", acks);
    end
    n_tests++;
    if (bad_rd !== 0) begin
      n_fail++;
      $display("FAIL nosel_rdata_hold: got %0d changed cycles expected 0", bad_rd);
    end
    do_txn(0, 1'b0, 8'h07, 32'h0, 1'b0, lat, rd, aa);
    n_tests++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL nosel_read_07: got 0x%08h expected 0x00000000", rd);
    end
  endtask

  task automatic test_drop_req();
    int lat; logic [31:0] rd; logic aa;
    do_txn(2, 1'b1, 8'h0A, 32'hA5A5A5A5, 1'b0, lat, rd, aa);
    n_tests++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL w3_write_latency: got %0d expected 4", lat);
    end
    do_txn(2, 1'b0, 8'h0A, 32'h0, 1'b1, lat, rd, aa);
    n_tests++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL drop_read_latency: got %0d expected 4", lat);
    end
    n_tests++;
    if (rd !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL drop_read_data: got 0x%08h expected 0xa5a5a5a5", rd);
    end
    n_tests++;
    if (aa !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_ack_width: ack after got %b expected 0", aa);
    end
  endtask

  task automatic test_alias();
    int lat; logic [31:0] rd; logic aa;
    do_txn(3, 1'b1, 8'h25, 32'h00000042, 1'b0, lat, rd, aa);
    do_txn(3, 1'b0, 8'h05, 32'h0, 1'b0, lat, rd, aa);
    n_tests++;
    if (rd !== 32'h00000042) begin
      n_fail++;
      $display("FAIL alias_read_05: got 0x%08h expected 0x00000042", rd);
    end
    do_txn(3, 1'b0, 8'hE5, 32'h0, 1'b0, lat, rd, aa);
    n_tests++;
    if (rd !== 32'h00000042) begin
      n_fail++;
      $display("FAIL alias_read_e5: got 0x%08h expected 0x00000042", rd);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_wait();
    test_wait1();
    test_back_to_back();
    test_no_sel();
    test_drop_req();
    test_alias();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
